// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_pkg
// Description : Shared opcodes, select/ALU encodings, FSM states and
//               instruction classes for the BIP multi-cycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

  // Instruction opcodes (low five bits of the opcode field)
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_JMP  = 5'b01010;
  localparam logic [4:0] OP_AND  = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_OR   = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;

  // Accumulator input select
  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // ALU operation
  localparam logic [1:0] ALU_SUB = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    HALTED   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CL_IMM     = 3'd0,
    CL_MEM     = 3'd1,
    CL_STORE   = 3'd2,
    CL_BEQ     = 3'd3,
    CL_BNE     = 3'd4,
    CL_JUMP    = 3'd5,
    CL_HALT    = 3'd6,
    CL_ILLEGAL = 3'd7
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/bip_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : bip_op_decode
// Description : Combinational opcode classifier: instruction class, datapath
//               selects, ALU op and control flags for one opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_op_decode
  import bip_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] ir,
  output op_class_t           op_class,
  output logic [1:0]          sel_a,
  output logic                sel_b,
  output logic [1:0]          op,
  output logic                uses_ram,
  output logic                is_store,
  output logic                is_branch,
  output logic                legal
);

  logic upper_zero;

  // Opcode bits above the five defined ones must be zero for a legal opcode
  generate
    if (OPCODE_W > 5) begin : g_wide
      assign upper_zero = (ir[OPCODE_W-1:5] == '0);
    end else begin : g_narrow
      assign upper_zero = 1'b1;
    end
  endgenerate

  // Classify the opcode and derive the datapath selects it needs
  always_comb begin
    op_class  = CL_ILLEGAL;
    sel_a     = SEL_A_RAM;
    sel_b     = 1'b0;
    op        = ALU_SUB;
    uses_ram  = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    case (ir[4:0])
      OP_HALT: op_class = CL_HALT;
      OP_STO:  begin op_class = CL_STORE; is_store = 1'b1; end
      OP_LD:   begin op_class = CL_MEM; uses_ram = 1'b1; sel_a = SEL_A_RAM; end
      OP_LDI:  begin op_class = CL_IMM; sel_a = SEL_A_IMM; sel_b = 1'b1; end
      OP_ADD:  begin op_class = CL_MEM; uses_ram = 1'b1; sel_a = SEL_A_ALU; op = ALU_ADD; end
      OP_ADDI: begin op_class = CL_IMM; sel_a = SEL_A_ALU; sel_b = 1'b1; op = ALU_ADD; end
      OP_SUB:  begin op_class = CL_MEM; uses_ram = 1'b1; sel_a = SEL_A_ALU; op = ALU_SUB; end
      OP_SUBI: begin op_class = CL_IMM; sel_a = SEL_A_ALU; sel_b = 1'b1; op = ALU_SUB; end
      OP_BEQ:  begin op_class = CL_BEQ;  is_branch = 1'b1; end
      OP_BNE:  begin op_class = CL_BNE;  is_branch = 1'b1; end
      OP_JMP:  begin op_class = CL_JUMP; is_branch = 1'b1; end
      OP_AND:  begin op_class = CL_MEM; uses_ram = 1'b1; sel_a = SEL_A_ALU; op = ALU_AND; end
      OP_ANDI: begin op_class = CL_IMM; sel_a = SEL_A_ALU; sel_b = 1'b1; op = ALU_AND; end
      OP_OR:   begin op_class = CL_MEM; uses_ram = 1'b1; sel_a = SEL_A_ALU; op = ALU_OR; end
      OP_ORI:  begin op_class = CL_IMM; sel_a = SEL_A_ALU; sel_b = 1'b1; op = ALU_OR; end
      default: op_class = CL_ILLEGAL;
    endcase
    if (!upper_zero) begin
      op_class  = CL_ILLEGAL;
      uses_ram  = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
    end
    legal = (op_class != CL_ILLEGAL);
  end

endmodule
`default_nettype wire

// File: rtl/bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : bip_control_unit
// Description : Multi-cycle BIP control FSM (fetch / execute / memory-wait)
//               with configurable data-RAM read latency, halt and
//               illegal-opcode trap, and a retired-instruction counter.
//               All control outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int RAM_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                acc_zero,
  output logic                WrPC,
  output logic                SelPC,
  output logic [1:0]          SelA,
  output logic                SelB,
  output logic                WrAcc,
  output logic [1:0]          Op,
  output logic                WrRam,
  output logic                RdRam,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  // Wait counter preload so that the final MEM_WAIT cycle sits at count 0
  localparam logic [2:0] LAT_M1 = (RAM_LAT > 0) ? 3'(RAM_LAT - 1) : 3'd0;

  state_t              state;
  logic [OPCODE_W-1:0] ir;
  logic [2:0]          wait_cnt;

  logic [OPCODE_W-1:0] dec_in;
  op_class_t           dec_class;
  logic [1:0]          dec_sel_a;
  logic                dec_sel_b;
  logic [1:0]          dec_op;
  logic                dec_uses_ram;
  logic                dec_is_store;
  logic                dec_is_branch;
  logic                dec_legal;
  logic                branch_taken;

  // In FETCH the opcode about to be latched is decoded so the first execute
  // cycle's outputs can be registered; afterwards the held IR is decoded.
  assign dec_in = (state == FETCH) ? Opcode : ir;

  bip_op_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .ir        (dec_in),
    .op_class  (dec_class),
    .sel_a     (dec_sel_a),
    .sel_b     (dec_sel_b),
    .op        (dec_op),
    .uses_ram  (dec_uses_ram),
    .is_store  (dec_is_store),
    .is_branch (dec_is_branch),
    .legal     (dec_legal)
  );

  // acc_zero is sampled at fetch, when the previous instruction's write is done
  assign branch_taken = (dec_class == CL_JUMP) ||
                        ((dec_class == CL_BEQ) &&  acc_zero) ||
                        ((dec_class == CL_BNE) && !acc_zero);

  // Instruction sequencer, wait counter, retired counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ir       <= '0;
      wait_cnt <= '0;
      retired  <= '0;
      WrPC     <= 1'b0;
      SelPC    <= 1'b0;
      SelA     <= SEL_A_RAM;
      SelB     <= 1'b0;
      WrAcc    <= 1'b0;
      Op       <= ALU_SUB;
      WrRam    <= 1'b0;
      RdRam    <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (WrPC) begin
        retired <= retired + CNT_W'(1);
      end
      // Strobes are single-cycle unless a state explicitly re-asserts them
      WrPC  <= 1'b0;
      SelPC <= 1'b0;
      SelA  <= SEL_A_RAM;
      SelB  <= 1'b0;
      WrAcc <= 1'b0;
      Op    <= ALU_SUB;
      WrRam <= 1'b0;
      RdRam <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (instr_valid) begin
            ir <= Opcode;
            if (!dec_legal) begin
              state   <= HALTED;
              illegal <= 1'b1;
            end else if (dec_class == CL_HALT) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= EXEC;
              if (dec_is_store) begin
                WrRam <= 1'b1;
                WrPC  <= 1'b1;
              end else if (dec_is_branch) begin
                WrPC  <= 1'b1;
                SelPC <= branch_taken;
              end else if (dec_uses_ram) begin
                RdRam <= 1'b1;
                SelA  <= dec_sel_a;
                SelB  <= dec_sel_b;
                Op    <= dec_op;
                if (RAM_LAT == 0) begin
                  WrAcc <= 1'b1;
                  WrPC  <= 1'b1;
                end
              end else begin
                WrAcc <= 1'b1;
                WrPC  <= 1'b1;
                SelA  <= dec_sel_a;
                SelB  <= dec_sel_b;
                Op    <= dec_op;
              end
            end
          end
        end
        EXEC: begin
          if (dec_uses_ram && (RAM_LAT != 0)) begin
            state    <= MEM_WAIT;
            wait_cnt <= LAT_M1;
            RdRam    <= 1'b1;
            SelA     <= dec_sel_a;
            SelB     <= dec_sel_b;
            Op       <= dec_op;
            if (LAT_M1 == 3'd0) begin
              WrAcc <= 1'b1;
              WrPC  <= 1'b1;
            end
          end else begin
            state <= FETCH;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state <= FETCH;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
            RdRam    <= 1'b1;
            SelA     <= dec_sel_a;
            SelB     <= dec_sel_b;
            Op       <= dec_op;
            if (wait_cnt == 3'd1) begin
              WrAcc <= 1'b1;
              WrPC  <= 1'b1;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip_control_unit
// Description : Scoreboard bench for bip_control_unit (RAM_LAT=2, CNT_W=4).
//               Expected per-cycle output words are queued when an
//               instruction is presented and compared as the core executes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control_unit;

  localparam int OPCODE_W = 5;
  localparam int RAM_LAT  = 2;
  localparam int CNT_W    = 4;

  localparam logic [4:0] T_HALT = 5'b00000, T_STO  = 5'b00001, T_LD   = 5'b00010;
  localparam logic [4:0] T_LDI  = 5'b00011, T_ADD  = 5'b00100, T_ADDI = 5'b00101;
  localparam logic [4:0] T_SUB  = 5'b00110, T_SUBI = 5'b00111, T_BEQ  = 5'b01000;
  localparam logic [4:0] T_BNE  = 5'b01001, T_JMP  = 5'b01010, T_AND  = 5'b01011;
  localparam logic [4:0] T_ANDI = 5'b01100, T_OR   = 5'b01101, T_ORI  = 5'b01110;

  // outs = {WrPC, SelPC, SelA[1:0], SelB, WrAcc, Op[1:0], WrRam, RdRam, halted, illegal}
  localparam logic [11:0] M_ALL    = 12'hFFF;
  localparam logic [11:0] M_STROBE = 12'hC4F;

  typedef struct packed {
    logic [11:0] exp;
    logic [11:0] mask;
  } sb_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                run = 1'b0;
  logic                instr_valid = 1'b0;
  logic [OPCODE_W-1:0] Opcode = '0;
  logic                acc_zero = 1'b0;
  logic                WrPC, SelPC, SelB, WrAcc, WrRam, RdRam, halted, illegal;
  logic [1:0]          SelA, Op;
  logic [CNT_W-1:0]    retired;
  logic [11:0]         outs;

  sb_t                 exp_q[$];
  logic [CNT_W-1:0]    exp_retired = '0;
  int                  n_checks = 0;
  int                  n_fail = 0;

  assign outs = {WrPC, SelPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, halted, illegal};

  bip_control_unit #(
    .OPCODE_W (OPCODE_W),
    .RAM_LAT  (RAM_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .instr_valid (instr_valid),
    .Opcode      (Opcode),
    .acc_zero    (acc_zero),
    .WrPC        (WrPC),
    .SelPC       (SelPC),
    .SelA        (SelA),
    .SelB        (SelB),
    .WrAcc       (WrAcc),
    .Op          (Op),
    .WrRam       (WrRam),
    .RdRam       (RdRam),
    .halted      (halted),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic wrpc, input logic selpc, input logic [1:0] sela,
                                     input logic selb, input logic wracc, input logic [1:0] op,
                                     input logic wrram, input logic rdram, input logic h,
                                     input logic il);
    return {wrpc, selpc, sela, selb, wracc, op, wrram, rdram, h, il};
  endfunction

  function automatic logic [1:0] alu_of(input logic [4:0] opc);
    case (opc)
      T_ADD, T_ADDI: return 2'b01;
      T_AND, T_ANDI: return 2'b10;
      T_OR,  T_ORI:  return 2'b11;
      default:       return 2'b00;
    endcase
  endfunction

  task automatic push(input logic [11:0] e, input logic [11:0] m);
    sb_t s;
    s.exp  = e;
    s.mask = m;
    exp_q.push_back(s);
  endtask

  // Expected output trace of one instruction, straight from the opcode table
  task automatic push_expected(input logic [4:0] opc, input logic az);
    logic taken;
    case (opc)
      T_LDI: push(mk(1, 0, 2'b01, 1, 1, 2'b00, 0, 0, 0, 0), M_ALL);
      T_ADDI, T_SUBI, T_ANDI, T_ORI:
        push(mk(1, 0, 2'b10, 1, 1, alu_of(opc), 0, 0, 0, 0), M_ALL);
      T_STO: push(mk(1, 0, 2'b00, 0, 0, 2'b00, 1, 0, 0, 0), M_STROBE);
      T_LD, T_ADD, T_SUB, T_AND, T_OR: begin
        for (int i = 0; i < RAM_LAT; i++) begin
          push(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 0, 0), M_STROBE);
        end
        push(mk(1, 0, (opc == T_LD) ? 2'b00 : 2'b10, 0, 1, alu_of(opc), 0, 1, 0, 0), M_ALL);
      end
      T_BEQ, T_BNE, T_JMP: begin
        taken = (opc == T_JMP) || ((opc == T_BEQ) && az) || ((opc == T_BNE) && !az);
        push(mk(1, taken, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0), M_STROBE);
      end
      T_HALT: begin
        for (int i = 0; i < 20; i++) begin
          push(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0), M_ALL);
        end
      end
      default: begin
        for (int i = 0; i < 8; i++) begin
          push(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1), M_ALL);
        end
      end
    endcase
    if ((opc != T_HALT) && (opc <= T_ORI)) begin
      exp_retired = exp_retired + 1'b1;
    end
  endtask

  // Called at a falling edge with the core in FETCH
  task automatic run_instr(input logic [4:0] opc, input logic az, input bit hold_valid);
    sb_t e;
    int  cyc;
    cyc         = 0;
    Opcode      = opc;
    instr_valid = 1'b1;
    acc_zero    = az;
    push_expected(opc, az);
    @(negedge clk);
    if (hold_valid) begin
      Opcode = T_LDI;
    end else begin
      instr_valid = 1'b0;
      Opcode      = 5'($urandom);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk_eq($sformatf("out_%05b_c%0d", opc, cyc), {20'd0, outs & e.mask}, {20'd0, e.exp & e.mask});
      cyc++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk_eq($sformatf("retired_%05b", opc), 32'(retired), 32'(exp_retired));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    run         = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    exp_retired = '0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_eq("reset_outs", {20'd0, outs}, 32'd0);
    chk_eq("reset_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("idle_outs", {20'd0, outs}, 32'd0);

    // Enter FETCH and stall without a valid opcode
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      Opcode = 5'($urandom);
      chk_eq($sformatf("stall_c%0d", i), {20'd0, outs}, 32'd0);
      @(negedge clk);
    end

    run_instr(T_LDI, 1'b0, 1'b0);
    run_instr(T_ADD, 1'b0, 1'b0);
    run_instr(T_BEQ, 1'b1, 1'b0);
    run_instr(T_BNE, 1'b1, 1'b0);
    run_instr(T_BEQ, 1'b0, 1'b0);
    run_instr(T_BNE, 1'b0, 1'b0);
    run_instr(T_JMP, 1'b0, 1'b0);
    run_instr(T_STO, 1'b0, 1'b0);
    run_instr(T_LD,  1'b0, 1'b0);
    run_instr(T_SUB, 1'b0, 1'b0);
    run_instr(T_AND, 1'b0, 1'b0);
    run_instr(T_OR,  1'b0, 1'b0);
    run_instr(T_ADDI, 1'b0, 1'b0);
    run_instr(T_SUBI, 1'b0, 1'b0);
    run_instr(T_ANDI, 1'b0, 1'b0);
    run_instr(T_ORI,  1'b0, 1'b0);
    run_instr(T_HALT, 1'b0, 1'b1);

    // Illegal opcode trap
    apply_reset();
    run = 1'b1;
    @(negedge clk);
    run_instr(5'b11111, 1'b0, 1'b0);

    // Reset in the middle of a memory wait
    apply_reset();
    run = 1'b1;
    @(negedge clk);
    run_instr(T_LDI, 1'b0, 1'b0);
    run_instr(T_LDI, 1'b0, 1'b0);
    Opcode      = T_ADD;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk_eq("memwait_rdram", 32'(RdRam), 32'd1);
    #2;
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    chk_eq("abort_outs", {20'd0, outs}, 32'd0);
    chk_eq("abort_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    exp_retired = '0;
    @(negedge clk);
    chk_eq("post_abort_idle", {20'd0, outs}, 32'd0);
    chk_eq("post_abort_retired", 32'(retired), 32'd0);

    // Retired counter wrap with a 4-bit counter
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      run_instr(T_LDI, 1'b0, 1'b0);
    end
    chk_eq("retired_wrap", 32'(retired), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
